// File: rtl/seq_ctrl_pkg.sv
// Shared codes for the seq_ctrl sequencer: state encoding, mode select values
// and the y next-value select codes understood by the datapath.
package seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_L_INIT = 4'd1,
        ST_L_WAIT = 4'd2,
        ST_L_STEP = 4'd3,
        ST_L_DONE = 4'd4,
        ST_CNT    = 4'd5,
        ST_U_LOAD = 4'd6,
        ST_U_SEL  = 4'd7,
        ST_U_CLR  = 4'd8
    } state_e;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_LIST   = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_UPDATE = 2'd3;

    localparam logic [1:0] YSEL_NONE = 2'd0;
    localparam logic [1:0] YSEL_INC  = 2'd1;
    localparam logic [1:0] YSEL_NORM = 2'd2;

endpackage

// File: rtl/seq_ctrl_dwell_timer.sv
// Loadable down-counter pacing the LIST dwell; expire flags the last dwell cycle.
module dwell_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expire
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != {TW{1'b0}}) begin
            count_d = count_q - TW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {TW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TW'(1));

endmodule

// File: rtl/seq_ctrl.sv
// Moore sequencer driving the s accumulator and y register through the LIST,
// COUNT and UPDATE operations, with busy/done status and one-shot UPDATE.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int SW        = 4,
    parameter int TW        = 3,
    parameter int LIST_LEN  = 4,
    parameter int LIST_STEP = 2,
    parameter int DWELL     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic          y_inc,
    output logic [3:0]    state_o,
    output logic          active,
    output logic          busy,
    output logic          done,
    output logic          s_en,
    output logic          s_zero,
    output logic          s_add,
    output logic [SW-1:0] s_step,
    output logic          y_en,
    output logic          y_store_x,
    output logic [1:0]    y_sel
);

    if (LIST_STEP * (LIST_LEN - 1) >= 2**SW) begin : g_bad_sw
        $error("seq_ctrl: LIST_STEP*(LIST_LEN-1) does not fit in SW bits");
    end
    if (DWELL >= 2**TW) begin : g_bad_tw
        $error("seq_ctrl: DWELL does not fit in TW bits");
    end
    if (LIST_LEN < 2 || LIST_LEN > 16) begin : g_bad_len
        $error("seq_ctrl: LIST_LEN must be 2..16");
    end

    localparam logic [SW-1:0] INIT_VAL  = SW'(LIST_STEP * (LIST_LEN - 1));
    localparam logic [SW-1:0] STEP_VAL  = SW'(LIST_STEP);
    localparam logic [TW-1:0] DWELL_VAL = TW'(DWELL);
    localparam logic [3:0]    IDX_INIT  = 4'(LIST_LEN - 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          armed_q, armed_d;
    logic          tmr_expire;
    logic          active_q, busy_q, done_q, s_en_q, s_zero_q, s_add_q;
    logic          y_en_q, y_store_x_q;
    logic [1:0]    y_sel_q;
    logic [SW-1:0] s_step_q;
    logic          active_d, busy_d, done_d, s_en_d, s_zero_d, s_add_d;
    logic          y_en_d, y_store_x_d;
    logic [1:0]    y_sel_d;
    logic [SW-1:0] s_step_d;

    dwell_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state_q == ST_L_INIT) || (state_q == ST_L_STEP)),
        .load_val (DWELL_VAL),
        .expire   (tmr_expire)
    );

    // Next-state, step index and UPDATE arming.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_LIST && start) begin
                    state_d = ST_L_INIT;
                end else if (mode == MODE_COUNT && start) begin
                    state_d = ST_CNT;
                end else if (mode == MODE_UPDATE && armed_q) begin
                    state_d = ST_U_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_L_INIT: begin
                idx_d   = IDX_INIT;
                state_d = (DWELL == 0) ? ST_L_STEP : ST_L_WAIT;
            end
            ST_L_WAIT: begin
                if (tmr_expire) begin
                    state_d = (idx_q != 4'd0) ? ST_L_STEP : ST_L_DONE;
                end else begin
                    state_d = ST_L_WAIT;
                end
            end
            ST_L_STEP: begin
                idx_d = idx_q - 4'd1;
                // Without a dwell the index check has to look one step ahead.
                if (DWELL != 0) begin
                    state_d = ST_L_WAIT;
                end else if (idx_q != 4'd1) begin
                    state_d = ST_L_STEP;
                end else begin
                    state_d = ST_L_DONE;
                end
            end
            ST_L_DONE: state_d = ST_IDLE;
            ST_CNT: begin
                if (!start || mode != MODE_COUNT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CNT;
                end
            end
            ST_U_LOAD: state_d = ST_U_SEL;
            ST_U_SEL:  state_d = ST_U_CLR;
            ST_U_CLR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (mode != MODE_UPDATE) begin
            armed_d = 1'b1;
        end else if (state_q == ST_IDLE && state_d == ST_U_LOAD) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // Output decode of the upcoming state so the outputs can be registered.
    always_comb begin
        active_d    = (state_d == ST_L_INIT) || (state_d == ST_L_WAIT) ||
                      (state_d == ST_L_STEP) || (state_d == ST_L_DONE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = 1'b0;
        s_en_d      = 1'b0;
        s_zero_d    = 1'b0;
        s_add_d     = 1'b0;
        s_step_d    = {SW{1'b0}};
        y_en_d      = 1'b0;
        y_store_x_d = 1'b0;
        y_sel_d     = YSEL_NONE;
        case (state_d)
            ST_L_INIT: begin
                s_en_d = 1'b1; s_zero_d = 1'b1; s_step_d = INIT_VAL;
            end
            ST_L_STEP: begin
                s_en_d = 1'b1; s_step_d = STEP_VAL;
            end
            ST_L_DONE: begin
                s_en_d = 1'b1; s_zero_d = 1'b1; s_step_d = INIT_VAL; done_d = 1'b1;
            end
            ST_CNT: begin
                s_en_d = 1'b1; s_add_d = 1'b1; s_step_d = SW'(1); y_sel_d = YSEL_INC;
            end
            ST_U_LOAD: begin
                y_en_d = 1'b1; y_store_x_d = 1'b1;
            end
            ST_U_SEL: begin
                y_en_d = 1'b1; y_sel_d = YSEL_NORM;
            end
            ST_U_CLR: begin
                s_en_d = 1'b1; s_zero_d = 1'b1; done_d = 1'b1;
            end
            default: begin
                s_en_d = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            armed_q     <= 1'b1;
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s_en_q      <= 1'b0;
            s_zero_q    <= 1'b0;
            s_add_q     <= 1'b0;
            s_step_q    <= {SW{1'b0}};
            y_en_q      <= 1'b0;
            y_store_x_q <= 1'b0;
            y_sel_q     <= YSEL_NONE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            armed_q     <= armed_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s_en_q      <= s_en_d;
            s_zero_q    <= s_zero_d;
            s_add_q     <= s_add_d;
            s_step_q    <= s_step_d;
            y_en_q      <= y_en_d;
            y_store_x_q <= y_store_x_d;
            y_sel_q     <= y_sel_d;
        end
    end

    assign state_o   = state_q;
    assign active    = active_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign s_en      = s_en_q;
    assign s_zero    = s_zero_q;
    assign s_add     = s_add_q;
    assign s_step    = s_step_q;
    // The carry into y is the one path that must follow y_inc within the cycle.
    assign y_en      = y_en_q | ((state_q == ST_CNT) & y_inc);
    assign y_store_x = y_store_x_q;
    assign y_sel     = y_sel_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: a default instance plus a DWELL=0 instance,
// each driving a small model of the s accumulator.
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       start;
    logic       yinc_auto;
    logic       y_inc;

    logic [3:0] state_o, state0_o;
    logic       active, busy, done, s_en, s_zero, s_add, y_en, y_store_x;
    logic       active0, busy0, done0, s_en0, s_zero0, s_add0, y_en0, y_store_x0;
    logic [3:0] s_step, s_step0;
    logic [1:0] y_sel, y_sel0;
    logic [3:0] s_m  = 4'd0;
    logic [3:0] s0_m = 4'd0;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [3:0] st;
        bit         sc;
        logic [3:0] sv;
        bit         u;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign y_inc = yinc_auto && (s_m == 4'd2);

    seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .y_inc(y_inc),
        .state_o(state_o), .active(active), .busy(busy), .done(done),
        .s_en(s_en), .s_zero(s_zero), .s_add(s_add), .s_step(s_step),
        .y_en(y_en), .y_store_x(y_store_x), .y_sel(y_sel)
    );

    seq_ctrl #(.SW(4), .TW(3), .LIST_LEN(3), .LIST_STEP(1), .DWELL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .y_inc(y_inc),
        .state_o(state0_o), .active(active0), .busy(busy0), .done(done0),
        .s_en(s_en0), .s_zero(s_zero0), .s_add(s_add0), .s_step(s_step0),
        .y_en(y_en0), .y_store_x(y_store_x0), .y_sel(y_sel0)
    );

    // Datapath models of the accumulator behind each instance.
    always @(posedge clk) begin
        if (s_en) s_m <= s_zero ? s_step : (s_add ? s_m + s_step : s_m - s_step);
        if (s_en0) s0_m <= s_zero0 ? s_step0 : (s_add0 ? s0_m + s_step0 : s0_m - s_step0);
    end

    wire [31:0] obs  = {18'd0, active, busy, done, s_en, s_zero, s_add,
                        y_en, y_store_x, y_sel, s_step};
    wire [31:0] obs0 = {18'd0, active0, busy0, done0, s_en0, s_zero0, s_add0,
                        y_en0, y_store_x0, y_sel0, s_step0};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control outputs for a state, from the state table.
    function automatic logic [31:0] exp_ctrl(input logic [3:0] st, input bit u, input logic yi);
        logic act, bsy, dn, se, sz, sa, ye, ysx;
        logic [1:0] ys;
        logic [3:0] stp, iv, sv;
        iv = u ? 4'd2 : 4'd6;
        sv = u ? 4'd1 : 4'd2;
        act = (st >= 4'd1) && (st <= 4'd4);
        bsy = (st != 4'd0);
        {dn, se, sz, sa, ye, ysx} = 6'b0;
        ys = 2'd0;
        stp = 4'd0;
        case (st)
            4'd1: begin se = 1'b1; sz = 1'b1; stp = iv; end
            4'd3: begin se = 1'b1; stp = sv; end
            4'd4: begin se = 1'b1; sz = 1'b1; stp = iv; dn = 1'b1; end
            4'd5: begin se = 1'b1; sa = 1'b1; stp = 4'd1; ys = 2'd1; ye = yi; end
            4'd6: begin ye = 1'b1; ysx = 1'b1; end
            4'd7: begin ye = 1'b1; ys = 2'd2; end
            4'd8: begin se = 1'b1; sz = 1'b1; dn = 1'b1; end
            default: ;
        endcase
        return {18'd0, act, bsy, dn, se, sz, sa, ye, ysx, ys, stp};
    endfunction

    task automatic push_st(input logic [3:0] st, input bit sc, input logic [3:0] sv, input bit u);
        exp_t e;
        e.st = st; e.sc = sc; e.sv = sv; e.u = u;
        sb.push_back(e);
    endtask

    // Expected LIST timeline from the start sample edge onward.
    task automatic push_list(input int len, input int step, input int dwell, input bit u);
        logic [3:0] es, init;
        init = 4'(step * (len - 1));
        push_st(4'd1, 1'b0, 4'd0, u);
        es = init;
        for (int k = 0; k < len - 1; k++) begin
            for (int d = 0; d < dwell; d++) push_st(4'd2, 1'b1, es, u);
            push_st(4'd3, 1'b1, es, u);
            es = es - 4'(step);
        end
        for (int d = 0; d < dwell; d++) push_st(4'd2, 1'b1, es, u);
        push_st(4'd4, 1'b1, es, u);
        push_st(4'd0, 1'b1, init, u);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.u) begin
                check_vec("state0", {28'd0, state0_o}, {28'd0, e.st});
                check_vec("ctrl0", obs0, exp_ctrl(e.st, 1'b1, y_inc));
                if (e.sc) check_vec("s0", {28'd0, s0_m}, {28'd0, e.sv});
            end else begin
                check_vec("state", {28'd0, state_o}, {28'd0, e.st});
                check_vec("ctrl", obs, exp_ctrl(e.st, 1'b0, y_inc));
                if (e.sc) check_vec("s", {28'd0, s_m}, {28'd0, e.sv});
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && sb.size() > 0; i++) tick();
        check_vec("sb_drain", sb.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; start = 1'b0; yinc_auto = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("rst_state", {28'd0, state_o}, 32'd0);
        check_vec("rst_ctrl", obs, 32'd0);
        rst_n = 1'b1;
        tick();

        // LIST with default parameters: s 6,4,2,0 then reload with done.
        mode = 2'd1; start = 1'b1;
        push_list(4, 2, 2, 1'b0);
        tick();
        start = 1'b0;
        drain();

        // DWELL=0 instance: 2,1,0 on consecutive cycles then reload.
        start = 1'b1;
        push_list(3, 1, 0, 1'b1);
        tick();
        start = 1'b0;
        drain();
        repeat (12) tick();

        // UPDATE runs once while mode stays 3, and again after re-selection.
        mode = 2'd3;
        push_st(4'd6, 1'b0, 4'd0, 1'b0);
        push_st(4'd7, 1'b0, 4'd0, 1'b0);
        push_st(4'd8, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 17; i++) push_st(4'd0, 1'b1, 4'd0, 1'b0);
        drain();
        mode = 2'd0;
        push_st(4'd0, 1'b1, 4'd0, 1'b0);
        tick();
        mode = 2'd3;
        push_st(4'd6, 1'b1, 4'd0, 1'b0);
        push_st(4'd7, 1'b1, 4'd0, 1'b0);
        push_st(4'd8, 1'b1, 4'd0, 1'b0);
        push_st(4'd0, 1'b1, 4'd0, 1'b0);
        push_st(4'd0, 1'b1, 4'd0, 1'b0);
        drain();

        // COUNT for 10 cycles with y_inc raised while s==2.
        mode = 2'd2; start = 1'b1; yinc_auto = 1'b1;
        for (int i = 0; i < 10; i++) push_st(4'd5, 1'b1, 4'(i), 1'b0);
        push_st(4'd0, 1'b1, 4'd10, 1'b0);
        repeat (10) tick();
        start = 1'b0;
        drain();
        yinc_auto = 1'b0; mode = 2'd0;
        tick();

        // LIST is atomic against mode/start changes.
        mode = 2'd1; start = 1'b1;
        push_list(4, 2, 2, 1'b0);
        repeat (3) tick();
        mode = 2'd2; start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        drain();
        mode = 2'd0;
        tick();

        // Asynchronous reset in cycle 6 of a LIST run.
        mode = 2'd1; start = 1'b1;
        push_list(4, 2, 2, 1'b0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        sb.delete();
        rst_n = 1'b0;
        #1;
        check_vec("midrst_state", {28'd0, state_o}, 32'd0);
        check_vec("midrst_ctrl", obs, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1; mode = 2'd0;
        push_st(4'd0, 1'b0, 4'd0, 1'b0);
        push_st(4'd0, 1'b0, 4'd0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
